ysyx_idu_scb: RTL and testbench
===============================

Name: ysyx_idu_scb

Overview:
- Parametrised decode/issue front-end sitting between IFU and EXU.
- Buffers fetched instructions in a small FIFO and owns a per-register scoreboard of outstanding writes.
- Resolves RAW hazards against N forwarding channels and issues the head instruction with resolved operand values.
- Supports pipeline flush on misspeculation; the opcode decoder proper is a separate downstream module.

Parameters:
- XLEN, 32, datapath width.
- NR_REG, 16, architectural register count (16 = RV32E, 32 = RV32I); RW = $clog2(NR_REG).
- DEPTH, 2, instruction FIFO entries (power of two, >=2).
- N_FWD, 2, number of forwarding/bypass channels.
- CNT_W, 2, width of per-register outstanding-write counter.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  IFU instruction valid
- in_ready  out  1  FIFO can accept
- in_inst  in  32  instruction
- in_pc  in  XLEN  instruction PC
- in_spec  in  1  instruction fetched speculatively
- flush  in  1  kill all buffered instructions and scoreboard state
- rf_raddr1, rf_raddr2  out  RW  regfile read addresses (head rs1/rs2)
- rf_rdata1, rf_rdata2  in  XLEN  regfile read data (combinational)
- fwd_valid  in  N_FWD  forwarding channel valid
- fwd_rd  in  N_FWD*RW  forwarding destination register per channel
- fwd_data  in  N_FWD*XLEN  forwarding value per channel
- wb_valid  in  1  writeback retires one write
- wb_rd  in  RW  retired destination
- out_valid  out  1  head issuable
- out_ready  in  1  EXU accepts
- out_inst  out  32  head instruction
- out_pc  out  XLEN  head PC
- out_rs1v, out_rs2v  out  XLEN  resolved operands
- out_spec  out  1  head speculation flag
- stall_raw  out  1  head blocked by hazard (perf counter tap)

Behaviour:
- Reset:
  - FIFO empty, all counters 0.
  - in_ready=1; out_valid=0; stall_raw=0.
  - out_inst=0, out_pc=0, out_spec=0.
- FIFO:
  - Push when in_valid & in_ready; pop when out_valid & out_ready.
  - Simultaneous push+pop when full is allowed: in_ready = !full | (out_valid & out_ready).
  - Pointers wrap modulo DEPTH.
  - Latency: an instruction pushed in cycle N can issue in cycle N+1 at the earliest.
- Head decode, on opcode inst[6:0]; register indices truncated to RW bits:
  - rs1 used by all opcodes except LUI, AUIPC, JAL.
  - rs2 used by BRANCH, STORE, OP only.
  - rd written by LUI, AUIPC, JAL, JALR, LOAD, OP-IMM, OP, SYSTEM; never when rd==0.
- Operand resolution, per source:
  - Source is register 0 -> 0.
  - Else, if any channel has fwd_valid[i] & fwd_rd[i]==rs -> fwd_data of the lowest matching index.
  - Else -> rf_rdata.
  - Unused sources still output the resolved value.
- Hazard: head not empty and any used source with counter!=0 and no forwarding match.
- Structural stall: the head writes rd whose counter == 2^CNT_W-1.
- Issue:
  - out_valid = head present & !hazard & !structural.
  - stall_raw = head present & hazard.
  - out_inst, out_pc and out_spec show the head whenever the FIFO is not empty; 0 when empty.
- Scoreboard:
  - On issue with rd written, counter[rd] +1.
  - On wb_valid with wb_rd!=0, counter[wb_rd] -1; decrementing 0 is ignored.
  - Same-cycle issue and wb on the same register: net unchanged.
  - Counter[0] is always 0.
- Flush:
  - FIFO emptied and all counters cleared at the clock edge.
  - While flush=1: out_valid=0, in_ready=0, and wb_valid is ignored.
  - Flush has priority over all other events.
- Reset asserted mid-operation behaves identically to flush plus output reset.

Test Plan:
- Back-to-back independent ADDI x1,x0,5 then ADDI x2,x0,7 with out_ready=1 -> issue in consecutive cycles; counters[1]=1, [2]=1; out_rs1v=0.
- ADDI x3 issued, then ADD x4,x3,x3 with no forwarding -> stall_raw=1, out_valid=0 until wb_valid,wb_rd=3; issues the next cycle with rf_rdata values.
- Same RAW pair with fwd_valid=2'b11, fwd_rd=3,3, fwd_data=0xAA,0xBB -> issues immediately, out_rs1v=out_rs2v=0xAA (channel 0 priority).
- out_ready=0, DEPTH=2: push 3 instructions -> in_ready drops after 2; release out_ready with in_valid high -> simultaneous push/pop keeps in_ready=1; order preserved.
- Issue 3 writes to x5 without wb (CNT_W=2), then a 4th write to x5 -> structural stall; one wb_rd=5 -> the 4th issues the next cycle.
- FIFO full with x6 counter=2, assert flush with wb_valid,wb_rd=6 -> next cycle FIFO empty, counter[6]=0, in_ready=1; LUI x0 never changes counter[0].

Source files
------------

// File: rtl/ysyx_idu_scb_if.sv
// rtl/ysyx_idu_scb_if.sv - IFU/regfile/bypass/writeback/EXU signal bundle for ysyx_idu_scb
// Ports (slave = decode/issue side):
//   in_valid/in_ready/in_inst/in_pc/in_spec : instruction push from IFU
//   flush                                   : kill buffered instructions and scoreboard
//   rf_raddr1/2 -> rf_rdata1/2              : combinational regfile read of head sources
//   fwd_valid/fwd_rd/fwd_data               : N_FWD bypass channels, channel 0 in low bits
//   wb_valid/wb_rd                          : one retired write per cycle
//   out_valid/out_ready/out_inst/out_pc/out_rs1v/out_rs2v/out_spec : issue to EXU
//   stall_raw                               : head blocked by RAW hazard
interface ysyx_idu_scb_if #(
  parameter int XLEN   = 32,
  parameter int NR_REG = 16,
  parameter int N_FWD  = 2
);
  localparam int RW = $clog2(NR_REG);

  logic                    in_valid;
  logic                    in_ready;
  logic [31:0]             in_inst;
  logic [XLEN-1:0]         in_pc;
  logic                    in_spec;
  logic                    flush;
  logic [RW-1:0]           rf_raddr1;
  logic [RW-1:0]           rf_raddr2;
  logic [XLEN-1:0]         rf_rdata1;
  logic [XLEN-1:0]         rf_rdata2;
  logic [N_FWD-1:0]        fwd_valid;
  logic [N_FWD*RW-1:0]     fwd_rd;
  logic [N_FWD*XLEN-1:0]   fwd_data;
  logic                    wb_valid;
  logic [RW-1:0]           wb_rd;
  logic                    out_valid;
  logic                    out_ready;
  logic [31:0]             out_inst;
  logic [XLEN-1:0]         out_pc;
  logic [XLEN-1:0]         out_rs1v;
  logic [XLEN-1:0]         out_rs2v;
  logic                    out_spec;
  logic                    stall_raw;

  modport slave (
    input  in_valid, in_inst, in_pc, in_spec, flush,
    input  rf_rdata1, rf_rdata2,
    input  fwd_valid, fwd_rd, fwd_data,
    input  wb_valid, wb_rd,
    input  out_ready,
    output in_ready, rf_raddr1, rf_raddr2,
    output out_valid, out_inst, out_pc, out_rs1v, out_rs2v, out_spec, stall_raw
  );

  modport master (
    output in_valid, in_inst, in_pc, in_spec, flush,
    output rf_rdata1, rf_rdata2,
    output fwd_valid, fwd_rd, fwd_data,
    output wb_valid, wb_rd,
    output out_ready,
    input  in_ready, rf_raddr1, rf_raddr2,
    input  out_valid, out_inst, out_pc, out_rs1v, out_rs2v, out_spec, stall_raw
  );
endinterface

// File: rtl/ysyx_idu_scb.sv
// rtl/ysyx_idu_scb.sv - decode/issue front-end: instruction FIFO, write scoreboard, operand bypass
// Ports:
//   clk : clock
//   rst : synchronous active-high reset (same effect as flush, plus outputs back to idle)
//   bus : ysyx_idu_scb_if.slave, all IFU/regfile/bypass/writeback/EXU signals
module ysyx_idu_scb #(
  parameter int XLEN   = 32,
  parameter int NR_REG = 16,
  parameter int DEPTH  = 2,
  parameter int N_FWD  = 2,
  parameter int CNT_W  = 2
) (
  input  logic           clk,
  input  logic           rst,
  ysyx_idu_scb_if.slave  bus
);
  localparam int RW = $clog2(NR_REG);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [PW:0]      FULL_CNT = (PW+1)'(DEPTH);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // FIFO storage is not reset; every consumer is masked by the empty flag.
  logic [31:0]      inst_q [DEPTH];
  logic [XLEN-1:0]  pc_q   [DEPTH];
  logic             spec_q [DEPTH];
  logic [PW-1:0]    wptr_q, rptr_q;
  logic [PW:0]      cnt_q;

  logic [CNT_W-1:0] sb_q [NR_REG];
  logic [CNT_W-1:0] sb_d [NR_REG];

  logic             empty, full;
  logic [31:0]      h_inst;
  logic [6:0]       opc;
  logic [RW-1:0]    rs1, rs2, rd;
  logic             use1, use2, wr;
  logic             m1, m2;
  logic [XLEN-1:0]  v1, v2;
  logic             haz, strc;
  logic             issue, push, fire;

  assign empty  = (cnt_q == '0);
  assign full   = (cnt_q == FULL_CNT);
  assign h_inst = inst_q[rptr_q];
  assign opc    = h_inst[6:0];
  assign rs1    = h_inst[15 +: RW];
  assign rs2    = h_inst[20 +: RW];
  assign rd     = h_inst[7 +: RW];

  always_comb begin
    use1 = !(opc == OP_LUI || opc == OP_AUIPC || opc == OP_JAL);
    use2 = (opc == OP_BRANCH || opc == OP_STORE || opc == OP_OP);
    wr   = (opc == OP_LUI || opc == OP_AUIPC || opc == OP_JAL || opc == OP_JALR ||
            opc == OP_LOAD || opc == OP_IMM || opc == OP_OP || opc == OP_SYSTEM) &&
           (rd != '0);
  end

  // Walk channels high to low so the lowest matching index ends up winning.
  always_comb begin
    m1 = 1'b0;
    m2 = 1'b0;
    v1 = bus.rf_rdata1;
    v2 = bus.rf_rdata2;
    for (int i = N_FWD - 1; i >= 0; i--) begin
      if (bus.fwd_valid[i] && bus.fwd_rd[i*RW +: RW] == rs1) begin
        m1 = 1'b1;
        v1 = bus.fwd_data[i*XLEN +: XLEN];
      end
      if (bus.fwd_valid[i] && bus.fwd_rd[i*RW +: RW] == rs2) begin
        m2 = 1'b1;
        v2 = bus.fwd_data[i*XLEN +: XLEN];
      end
    end
    if (rs1 == '0) v1 = '0;
    if (rs2 == '0) v2 = '0;
  end

  // x0 never carries a pending write, so its sources cannot raise a hazard.
  assign haz  = !empty && ((use1 && sb_q[rs1] != '0 && !m1) ||
                           (use2 && sb_q[rs2] != '0 && !m2));
  assign strc = !empty && wr && (sb_q[rd] == CNT_MAX);

  assign issue = !empty && !haz && !strc && !bus.flush && !rst;
  assign fire  = issue && bus.out_ready;
  assign push  = bus.in_valid && bus.in_ready;

  assign bus.in_ready  = !bus.flush && (!full || fire);
  assign bus.out_valid = issue;
  assign bus.stall_raw = haz;
  assign bus.rf_raddr1 = rs1;
  assign bus.rf_raddr2 = rs2;
  assign bus.out_rs1v  = v1;
  assign bus.out_rs2v  = v2;
  assign bus.out_inst  = empty ? '0 : h_inst;
  assign bus.out_pc    = empty ? '0 : pc_q[rptr_q];
  assign bus.out_spec  = empty ? 1'b0 : spec_q[rptr_q];

  // Issue and retire to the same register cancel, so the counter never sees
  // a transient overflow or underflow.
  always_comb begin
    for (int r = 0; r < NR_REG; r++) begin
      logic inc, dec;
      inc     = fire && wr && (rd == RW'(r));
      dec     = bus.wb_valid && (bus.wb_rd == RW'(r));
      sb_d[r] = sb_q[r];
      if (r == 0) begin
        sb_d[r] = '0;
      end else if (inc && !dec) begin
        sb_d[r] = sb_q[r] + 1'b1;
      end else if (dec && !inc && sb_q[r] != '0) begin
        sb_d[r] = sb_q[r] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      for (int r = 0; r < NR_REG; r++) sb_q[r] <= '0;
    end else begin
      if (push) begin
        inst_q[wptr_q] <= bus.in_inst;
        pc_q[wptr_q]   <= bus.in_pc;
        spec_q[wptr_q] <= bus.in_spec;
        wptr_q         <= wptr_q + 1'b1;
      end
      if (fire) rptr_q <= rptr_q + 1'b1;
      case ({push, fire})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
      for (int r = 0; r < NR_REG; r++) sb_q[r] <= sb_d[r];
    end
  end
endmodule

// File: tb/tb_ysyx_idu_scb.sv
// tb/tb_ysyx_idu_scb.sv - scoreboard bench for ysyx_idu_scb
module tb_ysyx_idu_scb;
  localparam int XLEN = 32, NR_REG = 16, DEPTH = 2, N_FWD = 2, CNT_W = 2;
  localparam int CMAX = (1 << CNT_W) - 1;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        spec;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ysyx_idu_scb_if #(.XLEN(XLEN), .NR_REG(NR_REG), .N_FWD(N_FWD)) bus ();

  ysyx_idu_scb #(.XLEN(XLEN), .NR_REG(NR_REG), .DEPTH(DEPTH), .N_FWD(N_FWD), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  logic [31:0] rf_mem [NR_REG];
  assign bus.rf_rdata1 = rf_mem[bus.rf_raddr1];
  assign bus.rf_rdata2 = rf_mem[bus.rf_raddr2];

  ent_t        exp_q [$];
  int          cnt [NR_REG];
  int          checks = 0, fails = 0;
  int          issues = 0, raw_seen = 0, strc_seen = 0, full_seen = 0;
  logic [31:0] pc_ctr = 32'h8000_0000;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int fwd_hit(input int r);
    for (int i = 0; i < N_FWD; i++)
      if (bus.fwd_valid[i] && int'(bus.fwd_rd[i*4 +: 4]) == r) return i;
    return -1;
  endfunction

  function automatic logic [31:0] resolve(input int r);
    int h;
    if (r == 0) return 32'h0;
    h = fwd_hit(r);
    if (h >= 0) return bus.fwd_data[h*XLEN +: XLEN];
    return rf_mem[r];
  endfunction

  // Reference model: evaluated mid-cycle against the FIFO contents held in exp_q
  // and the outstanding-write counts in cnt, then advanced for the coming edge.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      for (int r = 0; r < NR_REG; r++) cnt[r] = 0;
    end else begin
      bit present, haz, strc, use1, use2, wr, ev, fire;
      int rs1, rs2, rd;
      logic [6:0] op;
      ent_t h;
      present = exp_q.size() != 0;
      haz = 0; strc = 0; wr = 0; rd = 0;
      if (present) begin
        h    = exp_q[0];
        op   = h.inst[6:0];
        rs1  = int'(h.inst[19:15]) % NR_REG;
        rs2  = int'(h.inst[24:20]) % NR_REG;
        rd   = int'(h.inst[11:7]) % NR_REG;
        use1 = !(op inside {7'h37, 7'h17, 7'h6f});
        use2 = op inside {7'h63, 7'h23, 7'h33};
        wr   = (op inside {7'h37, 7'h17, 7'h6f, 7'h67, 7'h03, 7'h13, 7'h33, 7'h73}) && rd != 0;
        haz  = (use1 && cnt[rs1] != 0 && fwd_hit(rs1) < 0) ||
               (use2 && cnt[rs2] != 0 && fwd_hit(rs2) < 0);
        strc = wr && cnt[rd] == CMAX;
        chk("out_inst", bus.out_inst, h.inst);
        chk("out_pc", bus.out_pc, h.pc);
        chk("out_spec", bus.out_spec, h.spec);
        chk("rf_raddr1", bus.rf_raddr1, rs1);
        chk("rf_raddr2", bus.rf_raddr2, rs2);
        chk("out_rs1v", bus.out_rs1v, resolve(rs1));
        chk("out_rs2v", bus.out_rs2v, resolve(rs2));
      end else begin
        chk("out_inst_empty", bus.out_inst, 0);
        chk("out_pc_empty", bus.out_pc, 0);
        chk("out_spec_empty", bus.out_spec, 0);
      end
      ev   = present && !haz && !strc && !bus.flush;
      fire = ev && bus.out_ready;
      if (present && haz) raw_seen++;
      if (present && strc) strc_seen++;
      if (exp_q.size() == DEPTH) full_seen++;
      chk("out_valid", bus.out_valid, ev);
      chk("stall_raw", bus.stall_raw, present && haz);
      chk("in_ready", bus.in_ready, !bus.flush && (exp_q.size() < DEPTH || fire));
      if (bus.flush) begin
        exp_q.delete();
        for (int r = 0; r < NR_REG; r++) cnt[r] = 0;
      end else begin
        if (fire) begin
          void'(exp_q.pop_front());
          issues++;
          if (wr) cnt[rd]++;
        end
        if (bus.wb_valid && bus.wb_rd != 0 && cnt[bus.wb_rd] > 0) cnt[bus.wb_rd]--;
      end
    end
  end

  // Called just after a rising edge with stimulus already applied; returns just
  // after the next rising edge. Accepted instructions join the expected FIFO at
  // the edge that stores them in the DUT.
  task automatic tick();
    bit   acc;
    ent_t e;
    #2;
    acc = bus.in_valid && bus.in_ready && !rst;
    e.inst = bus.in_inst; e.pc = bus.in_pc; e.spec = bus.in_spec;
    @(posedge clk);
    if (acc) begin
      exp_q.push_back(e);
      pc_ctr += 32'd4;
    end
    #1;
  endtask

  task automatic idle();
    bus.in_valid = 0; bus.in_inst = 0; bus.in_pc = 0; bus.in_spec = 0;
    bus.flush = 0; bus.fwd_valid = 0; bus.fwd_rd = 0; bus.fwd_data = 0;
    bus.wb_valid = 0; bus.wb_rd = 0; bus.out_ready = 1;
  endtask

  task automatic send(input logic [31:0] inst);
    bus.in_valid = 1; bus.in_inst = inst; bus.in_pc = pc_ctr; bus.in_spec = 1'($urandom);
  endtask

  function automatic logic [31:0] addi(input int rd, input int rs, input int imm);
    return {12'(imm), 5'(rs), 3'b000, 5'(rd), 7'h13};
  endfunction
  function automatic logic [31:0] add(input int rd, input int a, input int b);
    return {7'h0, 5'(b), 5'(a), 3'b000, 5'(rd), 7'h33};
  endfunction
  function automatic logic [31:0] rand_inst();
    logic [6:0] ops [10] = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h73};
    logic [31:0] r;
    int k;
    r = $urandom;
    k = $urandom_range(0, 10);
    if (k < 10) r[6:0] = ops[k];
    return r;
  endfunction

  task automatic flush_now();
    idle(); bus.flush = 1; tick(); idle();
  endtask

  initial begin
    for (int r = 0; r < NR_REG; r++) rf_mem[r] = $urandom;
    idle();
    repeat (3) @(posedge clk);
    #1 rst = 0;
    tick();

    // independent back-to-back issue, then a reader of both results must wait
    send(addi(1, 0, 5)); tick();
    send(addi(2, 0, 7)); tick();
    send(add(3, 1, 2));  tick();
    idle(); repeat (2) tick();
    bus.wb_valid = 1; bus.wb_rd = 1; tick();
    bus.wb_rd = 2; tick();
    idle(); repeat (2) tick();
    flush_now();

    // RAW stall released by writeback
    send(addi(3, 0, 1)); tick();
    send(add(4, 3, 3));  tick();
    idle(); repeat (3) tick();
    bus.wb_valid = 1; bus.wb_rd = 3; tick();
    idle(); repeat (2) tick();
    flush_now();

    // RAW resolved by bypass, channel 0 wins
    send(addi(3, 0, 1)); tick();
    send(add(4, 3, 3));
    bus.fwd_valid = 2'b11; bus.fwd_rd = {4'd3, 4'd3}; bus.fwd_data = {32'hBB, 32'hAA};
    tick();
    bus.in_valid = 0; repeat (2) tick();
    idle(); tick();
    flush_now();

    // fill with EXU stalled, then simultaneous push/pop while full
    bus.out_ready = 0;
    send(addi(0, 0, 1)); tick();
    send(addi(0, 0, 2)); tick();
    send(addi(0, 0, 3)); tick();
    tick();
    bus.out_ready = 1; tick();
    idle(); repeat (3) tick();

    // structural stall on a saturated counter
    flush_now();
    for (int k = 0; k < 4; k++) begin send(addi(5, 0, k)); tick(); end
    idle(); repeat (2) tick();
    bus.wb_valid = 1; bus.wb_rd = 5; tick();
    idle(); repeat (2) tick();

    // flush beats a same-cycle writeback; x0 destination never counted
    flush_now();
    send(addi(6, 0, 1)); tick();
    send(addi(6, 0, 2)); tick();
    idle(); tick();
    bus.out_ready = 0;
    send(add(7, 6, 6)); tick();
    send(addi(8, 6, 1)); tick();
    idle(); bus.flush = 1; bus.wb_valid = 1; bus.wb_rd = 6; tick();
    idle(); tick();
    send({20'h12345, 5'd0, 7'h37}); tick();
    send(add(9, 0, 0)); tick();
    idle(); repeat (2) tick();

    // randomized traffic with occasional flush and mid-run reset
    for (int n = 0; n < 3000; n++) begin
      idle();
      if ($urandom_range(0, 99) < 70) send(rand_inst());
      bus.out_ready = ($urandom_range(0, 99) < 80);
      bus.fwd_valid = 2'($urandom) & 2'($urandom);
      bus.fwd_rd    = 8'($urandom);
      bus.fwd_data  = {$urandom, $urandom};
      bus.wb_valid  = ($urandom_range(0, 99) < 50);
      bus.wb_rd     = 4'($urandom);
      bus.flush     = ($urandom_range(0, 99) == 0);
      rst           = ($urandom_range(0, 399) == 0);
      tick();
    end
    rst = 0;

    // drain: bounded, retire every register in turn
    for (int n = 0; n < 400 && exp_q.size() != 0; n++) begin
      idle();
      bus.wb_valid = 1; bus.wb_rd = 4'(n);
      tick();
    end
    idle(); tick();
    chk("drain_empty", exp_q.size(), 0);
    chk("saw_issue", issues > 100, 1);
    chk("saw_raw_stall", raw_seen > 0, 1);
    chk("saw_struct_stall", strc_seen > 0, 1);
    chk("saw_full", full_seen > 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
